axi_lite_master_cmd: RTL and testbench
======================================

// Module: axi_lite_master_cmd
// PURPOSE
//  AXI-Lite initiator. Turns a simple valid/ready command stream into single AXI-Lite read or write transactions.
//  Returns each result on a valid/ready response stream.
//  Drives the register-array slave in the UVM closure environment; one transaction outstanding at a time.
//  Keeps saturating counters of completed writes, completed reads and error responses.
// PARAMETERS
//  CNT_W  16  width of wr_cnt / rd_cnt / err_cnt (saturating)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst_n      in   1   synchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1   1=write, 0=read
//  cmd_addr   in   32  byte address, forwarded unmodified to awaddr/araddr
//  cmd_wdata  in   32  write data
//  cmd_wstrb  in   4   write byte strobes
//  awaddr     out  32  / awvalid out 1 / awready in 1    AW channel
//  wdata      out  32  / wstrb out 4 / wvalid out 1 / wready in 1    W channel
//  bresp      in   2   / bvalid in 1 / bready out 1    B channel
//  araddr     out  32  / arvalid out 1 / arready in 1    AR channel
//  rdata      in   32  / rresp in 2 / rvalid in 1 / rready out 1    R channel
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_write  out  1   echo of cmd_write for this response
//  rsp_rdata  out  32  captured rdata (reads); 0 for writes
//  rsp_resp   out  2   captured bresp/rresp
//  wr_cnt     out  CNT_W  completed B handshakes
//  rd_cnt     out  CNT_W  completed R handshakes
//  err_cnt    out  CNT_W  B/R handshakes with resp!=2'b00
// BEHAVIOUR
//  Reset (rst_n=0 at posedge), also mid-transaction:
//   - state=IDLE; all *valid, bready, rready, rsp_valid = 0.
//   - awaddr/araddr/wdata/wstrb/rsp_* and counters = 0.
//   - Abandoned slave responses are not tracked.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//   - All outputs are registered; cmd_ready=1 only in IDLE.
//  IDLE:
//   - write cmd accepted -> WR_REQ; awvalid=wvalid=1 next cycle; addr/data/strb latched.
//   - read cmd accepted  -> RD_REQ; arvalid=1 next cycle.
//  WR_REQ:
//   - AW and W tracked independently (aw_done, w_done).
//   - Each valid drops the cycle after its own handshake; never drops before it.
//   - Payload stays stable while valid.
//   - Both done (same or different cycles) -> WR_RESP with bready=1.
//  WR_RESP:
//   - On bvalid: capture bresp; bready=0; rsp_rdata=0; rsp_write=1 -> RSP.
//   - wr_cnt+1; err_cnt+1 if bresp!=0.
//  RD_REQ:
//   - arvalid held until arready -> RD_RESP with rready=1.
//  RD_RESP:
//   - On rvalid: capture rdata/rresp; rready=0; rsp_write=0 -> RSP.
//   - rd_cnt+1; err_cnt+1 if rresp!=0.
//  RSP:
//   - rsp_valid=1, rsp_* stable until rsp_ready -> IDLE.
//   - Next cmd accepted no earlier than the following cycle.
//  bvalid/rvalid outside WR_RESP/RD_RESP are ignored (bready/rready=0 there).
//  Latency, all readies=1 and slave B/R one cycle after request:
//   - cmd handshake at cycle 0; AW/W or AR valid at cycle 1; B/R handshake at cycle 2.
//   - rsp_valid at cycle 3.
//  Counters saturate at 2^CNT_W-1; no wrap.
//  Concurrent bvalid&&awvalid in same cycle impossible by construction (states are exclusive).
// TESTING
//  1 write addr 0x10, data 0xDEADBEEF, strb 0xF, all ready=1
//    -> awvalid at cycle 1, rsp_valid at cycle 3, rsp_resp=00, wr_cnt=1.
//  2 read addr 0x10 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_write=0, rd_cnt=1.
//  3 write 0x12345678 strb 0x3 to 0x10, then read
//    -> rsp_rdata=0xDEAD5678.
//  4 awready=0 for 3 cycles, wready=1
//    -> wvalid high 1 cycle; awvalid and awaddr stable 4 cycles; exactly one B; wr_cnt+1.
//  5 bresp=2'b10 injected; rsp_ready=0 for 5 cycles
//    -> rsp held stable with resp=10; cmd_ready=0; err_cnt=1.
//  6 rst_n=0 while arvalid=1 awaiting arready
//    -> next cycle arvalid=0, state IDLE, counters 0, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_master_cmd.sv
// AXI-Lite initiator: turns a valid/ready command stream into single AXI-Lite reads/writes,
// one outstanding, and keeps saturating counts of writes, reads and error responses.
module axi_lite_master_cmd #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    output logic [31:0]      awaddr,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_resp,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    state_t            state, state_d;
    logic              awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d, rsp_valid_d;
    logic [31:0]       awaddr_d, araddr_d, wdata_d, rsp_rdata_d;
    logic [3:0]        wstrb_d;
    logic              rsp_write_d;
    logic [1:0]        rsp_resp_d;
    logic [CNT_W-1:0]  wr_cnt_d, rd_cnt_d, err_cnt_d;

    // A write channel is finished once its valid has dropped or its handshake happens now.
    logic aw_done, w_done;
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default hold value first so no path infers a latch.
        state_d     = state;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        arvalid_d   = arvalid;
        bready_d    = bready;
        rready_d    = rready;
        rsp_valid_d = rsp_valid;
        awaddr_d    = awaddr;
        araddr_d    = araddr;
        wdata_d     = wdata;
        wstrb_d     = wstrb;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        wr_cnt_d    = wr_cnt;
        rd_cnt_d    = rd_cnt;
        err_cnt_d   = err_cnt;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid && awready) awvalid_d = 1'b0;
                if (wvalid && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    wr_cnt_d    = sat_inc(wr_cnt);
                    if (bresp != 2'b00) err_cnt_d = sat_inc(err_cnt);
                end
            end
            RD_REQ: begin
                if (arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    rd_cnt_d    = sat_inc(rd_cnt);
                    if (rresp != 2'b00) err_cnt_d = sat_inc(err_cnt);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            bready    <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            cmd_ready <= (state_d == IDLE);
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            arvalid   <= arvalid_d;
            bready    <= bready_d;
            rready    <= rready_d;
            rsp_valid <= rsp_valid_d;
            awaddr    <= awaddr_d;
            araddr    <= araddr_d;
            wdata     <= wdata_d;
            wstrb     <= wstrb_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
            err_cnt   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd with a behavioural register-array AXI-Lite slave.
// Counters are built 3 bits wide so saturation is reachable in a short run.
module tb_axi_lite_master_cmd;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [31:0]      cmd_addr, cmd_wdata;
    logic [3:0]       cmd_wstrb;
    logic [31:0]      awaddr, wdata, araddr, rdata, rsp_rdata;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp, rsp_resp;
    logic             rsp_valid, rsp_ready, rsp_write;
    logic [CNT_W-1:0] wr_cnt, rd_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    axi_lite_master_cmd #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: acts on the falling edge; handshakes it sees now complete at the next rising edge.
    bit          aw_rdy = 1'b1, w_rdy = 1'b1, ar_rdy = 1'b1;
    logic [1:0]  inj_bresp = 2'b00;
    int          b_count = 0;
    logic [31:0] mem [0:15];
    bit          aw_got, w_got, b_pend, r_pend, b_hs_next, r_hs_next;
    logic [31:0] s_addr, s_data, r_addr;
    logic [3:0]  s_strb;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        {aw_got, w_got, b_pend, r_pend, b_hs_next, r_hs_next} = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
        forever begin
            @(negedge clk);
            awready = aw_rdy; wready = w_rdy; arready = ar_rdy;
            if (!rst_n) begin
                {aw_got, w_got, b_pend, r_pend, b_hs_next, r_hs_next} = '0;
                bvalid = 1'b0; rvalid = 1'b0;
            end else begin
                if (b_hs_next) bvalid = 1'b0;
                if (r_hs_next) rvalid = 1'b0;
                if (b_pend) begin bvalid = 1'b1; bresp = inj_bresp; b_pend = 1'b0; end
                if (r_pend) begin
                    rvalid = 1'b1; rresp = 2'b00; rdata = mem[r_addr[5:2]]; r_pend = 1'b0;
                end
                if (awvalid && awready) begin aw_got = 1'b1; s_addr = awaddr; end
                if (wvalid && wready) begin w_got = 1'b1; s_data = wdata; s_strb = wstrb; end
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (s_strb[b]) mem[s_addr[5:2]][8*b +: 8] = s_data[8*b +: 8];
                    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
                end
                if (arvalid && arready) begin r_pend = 1'b1; r_addr = araddr; end
                b_hs_next = bvalid && bready;
                r_hs_next = rvalid && rready;
                if (b_hs_next) b_count++;
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int c0);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1;
        c0 = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        if (n >= 50) check("rsp_valid_wait", rsp_valid, 1);
        c = cyc;
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid_dropped", rsp_valid, 0);
    endtask

    int  c0, c1, b0, awv_n, wv_n;
    bit  stable, hold_ok;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        check("reset_counters", {wr_cnt, rd_cnt, err_cnt}, 9'b0);
        rst_n = 1'b1;

        // 1: write 0xDEADBEEF to 0x10
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, c0);
        @(negedge clk);
        check("t1_awvalid_cycle1", {awvalid, wvalid}, 2'b11);
        check("t1_awaddr", awaddr, 32'h10);
        check("t1_wdata", {wdata, wstrb}, {32'hDEADBEEF, 4'hF});
        wait_rsp(c1);
        check("t1_rsp_latency", c1 - c0 + 1, 3);
        check("t1_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        finish_rsp();
        check("t1_wr_cnt", wr_cnt, 1);

        // 2: read back 0x10
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, c0);
        @(negedge clk);
        check("t2_arvalid_cycle1", {arvalid, araddr}, {1'b1, 32'h10});
        wait_rsp(c1);
        check("t2_rsp_latency", c1 - c0 + 1, 3);
        check("t2_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'hDEADBEEF});
        finish_rsp();
        check("t2_rd_cnt", rd_cnt, 1);

        // 3: partial-strobe write then read
        send_cmd(1'b1, 32'h10, 32'h12345678, 4'h3, c0);
        wait_rsp(c1);
        finish_rsp();
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, c0);
        wait_rsp(c1);
        check("t3_rdata_merged", rsp_rdata, 32'hDEAD5678);
        finish_rsp();
        check("t3_counts", {wr_cnt, rd_cnt}, {3'd2, 3'd2});

        // 4: awready held low for 3 cycles, wready high
        #1 aw_rdy = 1'b0;
        b0 = b_count;
        send_cmd(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, c0);
        awv_n = 0; wv_n = 0; stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (awvalid) begin
                awv_n++;
                if (awaddr !== 32'h20) stable = 1'b0;
            end
            if (wvalid) wv_n++;
            if (i == 2) aw_rdy = 1'b1;
        end
        check("t4_awvalid_cycles", awv_n, 4);
        check("t4_wvalid_cycles", wv_n, 1);
        check("t4_awaddr_stable", stable, 1);
        wait_rsp(c1);
        check("t4_rsp_resp", rsp_resp, 2'b00);
        finish_rsp();
        check("t4_b_count", b_count - b0, 1);
        check("t4_wr_cnt", wr_cnt, 3);

        // 5: SLVERR response held while rsp_ready is low
        #1 inj_bresp = 2'b10;
        rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h30, 32'h0BADF00D, 4'hF, c0);
        wait_rsp(c1);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_resp === 2'b10 && rsp_write === 1'b1 &&
                  rsp_rdata === 32'h0 && cmd_ready === 1'b0)) hold_ok = 1'b0;
        end
        check("t5_rsp_held", hold_ok, 1);
        check("t5_err_cnt", err_cnt, 1);
        rsp_ready = 1'b1;
        inj_bresp = 2'b00;
        finish_rsp();
        check("t5_cmd_ready_back", cmd_ready, 1);
        check("t5_wr_cnt", wr_cnt, 4);

        // counter saturation: four more writes push wr_cnt past its 3-bit maximum
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b1, 32'h34, 32'h1 + i, 4'hF, c0);
            wait_rsp(c1);
            finish_rsp();
        end
        check("sat_wr_cnt", wr_cnt, 7);
        check("sat_other_cnts", {rd_cnt, err_cnt}, {3'd2, 3'd1});

        // 6: reset while arvalid waits on arready
        #1 ar_rdy = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, c0);
        @(negedge clk);
        check("t6_arvalid_pending", arvalid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_arvalid_cleared", {arvalid, rready, rsp_valid}, 3'b000);
        check("t6_araddr_cleared", araddr, 32'h0);
        check("t6_counters_cleared", {wr_cnt, rd_cnt, err_cnt}, 9'b0);
        ar_rdy = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_cmd_ready", cmd_ready, 1);
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, c0);
        wait_rsp(c1);
        check("t6_post_reset_read", rsp_rdata, 32'hDEAD5678);
        finish_rsp();
        check("t6_rd_cnt", rd_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
